// File: rtl/sm_uart_loader_pkg.sv
// Shared types, constants and helpers for the UART program loader.
`include "sm_loader.vh"

package sm_uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = `SM_SYNC_BYTE;

    // Frame parser states; encodings come from the shared include file.
    typedef enum logic [1:0] {
        LD_IDLE = `SM_ST_IDLE,
        LD_LEN  = `SM_ST_LEN,
        LD_DATA = `SM_ST_DATA,
        LD_CSUM = `SM_ST_CSUM
    } ld_state_t;

    // Serial receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clocks per bit, truncating.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sm_loader.vh
// Frame sync byte and loader FSM state encodings shared by the loader sources.
`ifndef SM_LOADER_VH
`define SM_LOADER_VH

`define SM_SYNC_BYTE 8'hA5

`define SM_ST_IDLE 2'd0
`define SM_ST_LEN  2'd1
`define SM_ST_DATA 2'd2
`define SM_ST_CSUM 2'd3

`endif

// File: rtl/sm_uart_rx.sv
// 8N1 UART receiver: synchronizes the line, finds the start edge, samples
// mid-bit and reports either a byte or a framing error at the stop sample.
module sm_uart_rx
    import sm_uart_loader_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_prev;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          stop_sample;

    assign rx_s = sync_q[1];

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // Bit timing: half a bit to the start-bit centre, then full bit periods.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    // A glitch that is high again at mid-start is dropped.
                    state_n   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign stop_sample = (state == RX_STOP) && (cnt == CNT_FULL);
    assign byte_valid  = stop_sample && rx_s;
    assign frame_err   = stop_sample && !rx_s;
    assign rx_byte     = shreg;

endmodule

// File: rtl/sm_uart_loader.sv
// Serial boot loader: parses SYNC/LEN/DATA/CSUM frames from the UART into
// instruction memory and holds the CPU in reset until a frame checks out.
module sm_uart_loader
    import sm_uart_loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic [31:0]       imAddr,
    output logic [31:0]       imData,
    output logic              cpu_rst,
    output logic              load_active,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    sm_uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    ld_state_t         state, state_n;
    logic [ADDR_W:0]   len_q, len_n;
    logic [ADDR_W:0]   wcnt_q, wcnt_n;
    logic [1:0]        bidx_q, bidx_n;
    logic [23:0]       asm_q, asm_n;
    logic [7:0]        csum_q, csum_n;
    logic              wr_vld_q, wr_vld_n;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
    logic [31:0]       wr_data_q, wr_data_n;
    logic              cpu_rst_q, cpu_rst_n;
    logic              active_q, active_n;
    logic              err_q, err_n;
    logic [ADDR_W:0]   wc_q, wc_n;
    logic              len_bad;
    logic              abort;

    logic [31:0] mem [0:DEPTH-1];

    assign len_bad = (rx_byte == 8'd0) || ({24'd0, rx_byte} > 32'(DEPTH));

    // Parser and status registers; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_IDLE;
            len_q     <= '0;
            wcnt_q    <= '0;
            bidx_q    <= '0;
            asm_q     <= '0;
            csum_q    <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_rst_q <= 1'b1;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
            wc_q      <= '0;
        end else begin
            state     <= state_n;
            len_q     <= len_n;
            wcnt_q    <= wcnt_n;
            bidx_q    <= bidx_n;
            asm_q     <= asm_n;
            csum_q    <= csum_n;
            wr_vld_q  <= wr_vld_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            cpu_rst_q <= cpu_rst_n;
            active_q  <= active_n;
            err_q     <= err_n;
            wc_q      <= wc_n;
        end
    end

    // Frame parsing: next state, word assembly, checksum and status updates.
    always_comb begin
        state_n   = state;
        len_n     = len_q;
        wcnt_n    = wcnt_q;
        bidx_n    = bidx_q;
        asm_n     = asm_q;
        csum_n    = csum_q;
        wr_vld_n  = 1'b0;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        cpu_rst_n = cpu_rst_q;
        active_n  = active_q;
        err_n     = err_q;
        wc_n      = wc_q;
        abort     = 1'b0;
        unique case (state)
            LD_IDLE: begin
                // Framing errors and stray bytes are simply ignored here.
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_n   = LD_LEN;
                    cpu_rst_n = 1'b1;
                    active_n  = 1'b1;
                    err_n     = 1'b0;
                    wcnt_n    = '0;
                    bidx_n    = '0;
                    csum_n    = '0;
                end
            end
            LD_LEN: begin
                if (rx_valid) begin
                    if (len_bad) begin
                        abort = 1'b1;
                    end else begin
                        len_n   = (ADDR_W+1)'(rx_byte);
                        state_n = LD_DATA;
                    end
                end else if (rx_ferr) begin
                    abort = 1'b1;
                end
            end
            LD_DATA: begin
                if (rx_valid) begin
                    csum_n = csum_q ^ rx_byte;
                    bidx_n = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: asm_n[7:0]   = rx_byte;
                        2'd1: asm_n[15:8]  = rx_byte;
                        2'd2: asm_n[23:16] = rx_byte;
                        default: begin
                            // Word complete: write lands in memory next clock.
                            wr_vld_n  = 1'b1;
                            wr_addr_n = wcnt_q[ADDR_W-1:0];
                            wr_data_n = {rx_byte, asm_q};
                            wcnt_n    = wcnt_q + 1'b1;
                            if (wcnt_n == len_q) state_n = LD_CSUM;
                        end
                    endcase
                end else if (rx_ferr) begin
                    abort = 1'b1;
                end
            end
            LD_CSUM: begin
                if (rx_valid) begin
                    if (rx_byte == csum_q) begin
                        state_n   = LD_IDLE;
                        cpu_rst_n = 1'b0;
                        active_n  = 1'b0;
                        wc_n      = len_q;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (rx_ferr) begin
                    abort = 1'b1;
                end
            end
            default: state_n = LD_IDLE;
        endcase
        // Any failure keeps the CPU in reset; written words are left in place.
        if (abort) begin
            state_n  = LD_IDLE;
            err_n    = 1'b1;
            active_n = 1'b0;
        end
    end

    // Single write port, one cycle behind word completion.
    always_ff @(posedge clk) begin
        if (wr_vld_q) mem[wr_addr_q] <= wr_data_q;
    end

    // Asynchronous read; addresses beyond the memory return a nop.
    assign imData = (imAddr[31:ADDR_W] == '0) ? mem[imAddr[ADDR_W-1:0]] : 32'h0;

    assign cpu_rst     = cpu_rst_q;
    assign load_active = active_q;
    assign load_error  = err_q;
    assign word_count  = wc_q;

endmodule

// File: tb/tb_sm_uart_loader.sv
// Randomized frame-level check of the UART loader against a stream model.
module tb_sm_uart_loader;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uart_rx = 1'b1;
    logic [31:0]       imAddr = 32'h0;
    logic [31:0]       imData;
    logic              cpu_rst;
    logic              load_active;
    logic              load_error;
    logic [ADDR_W:0]   word_count;

    sm_uart_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .imAddr      (imAddr),
        .imData      (imData),
        .cpu_rst     (cpu_rst),
        .load_active (load_active),
        .load_error  (load_error),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Everything sent since the last reset, with per-byte framing-error flags.
    logic [7:0] q[$];
    bit         fq[$];

    // Model state.
    logic [31:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    bit          m_rst;
    bit          m_act;
    bit          m_err;
    int          m_wc;

    // Latency from the last received byte to the cpu_rst falling edge.
    int   cyc = 0;
    int   last_bv = 0;
    int   fall_lat = 0;
    int   n_fall = 0;
    logic rst_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut.rx_valid) last_bv <= cyc;
        if (rst_prev && !cpu_rst) begin
            n_fall   <= n_fall + 1;
            fall_lat <= cyc - last_bv;
        end
        rst_prev <= cpu_rst;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ferr);
        q.push_back(b);
        fq.push_back(ferr);
        uart_rx = 1'b0;
        tick(DIV);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            tick(DIV);
        end
        uart_rx = !ferr;
        tick(DIV);
        uart_rx = 1'b1;
        tick(DIV);
    endtask

    function automatic logic [7:0] rnd_data();
        logic [7:0] d;
        d = 8'($urandom);
        if (d == 8'hA5) d = 8'h5A;
        return d;
    endfunction

    // Whole frame; ferr_at is the frame byte index given a low stop bit (-1: none).
    task automatic send_frame(input int n, input bit bad_cs, input int ferr_at);
        logic [7:0] fb[$];
        logic [7:0] cs;
        logic [7:0] d;
        cs = 8'h00;
        fb.push_back(8'hA5);
        fb.push_back(8'(n));
        for (int k = 0; k < 4 * n; k++) begin
            d = rnd_data();
            fb.push_back(d);
            cs ^= d;
        end
        fb.push_back(bad_cs ? ~cs : cs);
        foreach (fb[k]) send_byte(fb[k], k == ferr_at);
    endtask

    // Walk the byte stream since reset according to the frame rules.
    task automatic run_model();
        int i;
        int n;
        logic [7:0] cs;
        logic [31:0] word;
        bit ok;
        m_rst = 1'b1; m_act = 1'b0; m_err = 1'b0; m_wc = 0;
        i = 0;
        while (i < q.size()) begin
            if (fq[i] || q[i] != 8'hA5) begin i++; continue; end
            i++;
            m_rst = 1'b1; m_act = 1'b1; m_err = 1'b0;
            if (i >= q.size()) return;
            if (fq[i] || q[i] == 8'd0 || int'(q[i]) > DEPTH) begin
                m_err = 1'b1; m_act = 1'b0; i++; continue;
            end
            n = int'(q[i]);
            i++;
            cs = 8'h00;
            ok = 1'b1;
            for (int w = 0; w < n && ok; w++) begin
                word = 32'h0;
                for (int b = 0; b < 4 && ok; b++) begin
                    if (i >= q.size()) return;
                    if (fq[i]) ok = 1'b0;
                    else begin
                        word[8*b +: 8] = q[i];
                        cs ^= q[i];
                    end
                    i++;
                end
                if (ok) begin m_mem[w] = word; m_vld[w] = 1'b1; end
            end
            if (!ok) begin m_err = 1'b1; m_act = 1'b0; continue; end
            if (i >= q.size()) return;
            if (!fq[i] && q[i] == cs) begin m_rst = 1'b0; m_wc = n; end
            else m_err = 1'b1;
            m_act = 1'b0;
            i++;
        end
    endtask

    task automatic check_all();
        run_model();
        chk("cpu_rst", 32'(cpu_rst), 32'(m_rst));
        chk("load_active", 32'(load_active), 32'(m_act));
        chk("load_error", 32'(load_error), 32'(m_err));
        chk("word_count", 32'(word_count), 32'(m_wc));
        for (int a = 0; a < DEPTH; a++) begin
            if (m_vld[a]) begin
                imAddr = 32'(a);
                #0.5;
                chk($sformatf("imData[%0d]", a), imData, m_mem[a]);
            end
        end
    endtask

    task automatic frame_and_check(input int n, input bit bad_cs, input int ferr_at);
        int nf0;
        nf0 = n_fall;
        send_frame(n, bad_cs, ferr_at);
        check_all();
        chk("fall_cnt", 32'(n_fall - nf0), m_rst ? 32'd0 : 32'd1);
        if (!m_rst) chk("fall_lat", 32'(fall_lat), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        q.delete();
        fq.delete();
        tick(1);
    endtask

    initial begin
        logic [7:0] f36 [7];
        logic [7:0] f38 [4];
        int nf0;
        f36 = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h01, 8'h24, 8'h36};
        f38 = '{8'h00, 8'hFF, 8'hA5, 8'h00};

        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_load_active", 32'(load_active), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);

        // Reference single-word frame.
        nf0 = n_fall;
        foreach (f36[k]) send_byte(f36[k], 1'b0);
        check_all();
        imAddr = 32'h0;
        #0.5;
        chk("ref_mem0", imData, 32'h24010013);
        chk("ref_word_count", 32'(word_count), 32'd1);
        chk("ref_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("ref_fall_cnt", 32'(n_fall - nf0), 32'd1);
        chk("ref_fall_lat", 32'(fall_lat), 32'd1);

        // Bad checksum: words stay, CPU held.
        frame_and_check(2, 1'b1, -1);
        chk("badcs_err", 32'(load_error), 32'd1);
        chk("badcs_cpu_rst", 32'(cpu_rst), 32'd1);

        // Junk before SYNC, then LEN=0.
        foreach (f38[k]) send_byte(f38[k], 1'b0);
        check_all();
        chk("len0_err", 32'(load_error), 32'd1);

        // Framing error on second data byte, then a clean frame.
        frame_and_check(2, 1'b0, 3);
        chk("ferr_err", 32'(load_error), 32'd1);
        frame_and_check(3, 1'b0, -1);

        // LEN one past depth, then a frame filling the whole memory.
        send_byte(8'hA5, 1'b0);
        send_byte(8'(DEPTH + 1), 1'b0);
        check_all();
        frame_and_check(DEPTH, 1'b0, -1);

        // Random frames with optional junk, bad checksums and framing errors.
        repeat (8) begin
            int g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) send_byte(rnd_data(), 1'b0);
            frame_and_check($urandom_range(1, 4), $urandom_range(0, 3) == 0,
                            ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1);
        end

        // Reset in the middle of the data phase, then a full frame.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(rnd_data(), 1'b0);
        check_all();
        do_reset();
        check_all();
        frame_and_check(3, 1'b0, -1);

        // Out-of-range fetches read as nop.
        imAddr = 32'h40;
        #0.5;
        chk("oob_40", imData, 32'h0);
        imAddr = 32'(DEPTH);
        #0.5;
        chk("oob_depth", imData, 32'h0);
        imAddr = 32'h8000_0000;
        #0.5;
        chk("oob_top", imData, 32'h0);
        imAddr = 32'h0;
        #0.5;
        chk("in_range_0", imData, m_mem[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_uart_loader.md
SM_UART_LOADER -- requirements
Module: sm_uart_loader

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; divisor DIV = CLK_HZ/BAUD, integer truncation (434 at defaults).
REQ-003 Parameter ADDR_W, default 6, instruction memory word-address width; depth 2**ADDR_W words.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 uart_rx  input  1  asynchronous serial input, 8N1, idle high.
REQ-007 imAddr  input  32  CPU instruction word address (PC>>2).
REQ-008 imData  output  32  instruction word at imAddr.
REQ-009 cpu_rst  output  1  active-high hold-in-reset to CPU.
REQ-010 load_active  output  1  high while a frame is being received.
REQ-011 load_error  output  1  sticky error flag for the last frame.
REQ-012 word_count  output  ADDR_W+1  number of words written by the last successful load.

Function
REQ-013 uart_rx SHALL pass a 2-flop synchronizer before any use.
REQ-014 The UART receiver SHALL detect start on a falling edge, re-check low at DIV/2, then sample 8 data bits LSB-first and the stop bit each DIV clocks later.
REQ-015 A start bit found high at DIV/2 SHALL be discarded silently; return to idle.
REQ-016 A stop bit sampled low SHALL produce a framing error instead of a byte valid.
REQ-017 Byte valid SHALL be a 1-cycle pulse in the stop-bit sample cycle.
REQ-018 Frame format: SYNC 0xA5, LEN byte N (words), 4N data bytes little-endian per word, CSUM byte equal to XOR of all 4N data bytes.
REQ-019 FSM states: IDLE, LEN, DATA, CSUM; non-SYNC bytes in IDLE SHALL be ignored.
REQ-020 IDLE->LEN on SYNC byte; in that same cycle cpu_rst and load_active SHALL go high, load_error SHALL clear.
REQ-021 LEN: N in 1..2**ADDR_W -> DATA with write pointer 0; N=0 or N>2**ADDR_W -> error.
REQ-022 DATA: each 4th byte SHALL write the assembled word to memory at the pointer in the next clock, then increment the pointer; after N words -> CSUM.
REQ-023 CSUM match -> IDLE with cpu_rst low, load_active low, word_count=N, all in the cycle after the CSUM byte valid.
REQ-024 Error (bad LEN, CSUM mismatch, framing error in LEN/DATA/CSUM) -> IDLE, load_error=1, load_active=0, cpu_rst stays 1, word_count unchanged.
REQ-025 Framing error in IDLE SHALL be ignored.
REQ-026 Words already written by a failed frame SHALL remain in memory; no rollback.
REQ-027 imData SHALL be a combinational read of memory at imAddr[ADDR_W-1:0] when imAddr[31:ADDR_W]==0, else 32'h0 (nop).
REQ-028 A write and a read of the same address in one cycle SHALL return the old word on imData that cycle.
REQ-029 A SYNC byte arriving while the CPU runs SHALL start a new load and assert cpu_rst per REQ-020.

Reset
REQ-030 On rst: FSM IDLE, UART receiver idle, synchronizer flops 1, cpu_rst=1, load_active=0, load_error=0, word_count=0, pointers 0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 rst mid-frame SHALL abandon the frame; the next byte is parsed from IDLE.

Structure
REQ-033 Include file sm_loader.vh SHALL hold SYNC_BYTE and FSM state encodings.
REQ-034 Sub-module sm_uart_rx (REQ-013..017) SHALL be instantiated once; outputs byte, byte_valid, frame_err.
REQ-035 Memory SHALL be a plain reg array, synthesizable to MLAB/M10K with asynchronous read.

Verification (DIV=434)
REQ-036 Frame A5 01 13 00 01 24 36 -> mem[0]=32'h24010013, cpu_rst falls 1 clk after CSUM valid, word_count=1, load_error=0.
REQ-037 Frame A5 02 + 8 bytes + wrong CSUM -> load_error=1, cpu_rst stays 1, mem[0..1] hold the new words.
REQ-038 Bytes 00 FF A5 00 -> first two ignored, LEN=0 gives load_error=1, cpu_rst=1.
REQ-039 Stop bit forced low on 2nd data byte -> load_error=1, FSM IDLE, next valid frame loads correctly.
REQ-040 After load, imAddr=32'h40 (ADDR_W=6) -> imData=0; imAddr=0 -> mem[0].
REQ-041 rst asserted mid-DATA then full valid frame -> successful load, cpu_rst falls, word_count=N.
